// File: rtl/montgomery_sched.sv
// Round-robin scheduler for the shared Montgomery reducer: issues operands, flushes the pipe with dummies, routes results.
// Grant to rsp_valid is RED_LAT+1 cycles; requests wait only on arbitration, responses have no backpressure.
module montgomery_sched #(
  parameter int TAG_W   = 4,
  parameter int RED_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [25:0]      req0_x,
  input  logic [TAG_W-1:0] req0_tag,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [25:0]      req1_x,
  input  logic [TAG_W-1:0] req1_tag,

  output logic             rsp0_valid,
  output logic [14:0]      rsp0_y,
  output logic [TAG_W-1:0] rsp0_tag,

  output logic             rsp1_valid,
  output logic [14:0]      rsp1_y,
  output logic [TAG_W-1:0] rsp1_tag,

  output logic             red_en,
  output logic [25:0]      red_x,
  input  logic [14:0]      red_y,
  input  logic             red_valid,

  output logic             busy,
  output logic             err
);

  typedef struct packed {
    logic             live;
    logic             src;
    logic [TAG_W-1:0] tag;
  } shadow_t;

  logic             ptr;
  logic             contend;
  logic             gnt_vld;
  logic             gnt_src;
  logic [25:0]      gnt_x;
  logic [TAG_W-1:0] gnt_tag;
  logic             flush;
  logic             any_live;
  logic             mismatch;
  logic             err_q;
  shadow_t          shadow [RED_LAT];
  shadow_t          tail;

  // Arbitration: a lone requester always wins; the pointer only breaks ties.
  always_comb begin
    contend    = req0_valid & req1_valid;
    gnt_vld    = req0_valid | req1_valid;
    gnt_src    = contend ? ptr : req1_valid;
    req0_ready = gnt_vld & ~gnt_src;
    req1_ready = gnt_vld &  gnt_src;
    gnt_x      = gnt_src ? req1_x   : req0_x;
    gnt_tag    = gnt_src ? req1_tag : req0_tag;
  end

  // Entries 0..RED_LAT-2 still need reducer stage advances; the tail entry is already at the output.
  always_comb begin
    flush    = 1'b0;
    any_live = 1'b0;
    for (int i = 0; i < RED_LAT; i++) begin
      if (i < RED_LAT - 1) begin
        flush = flush | shadow[i].live;
      end
      any_live = any_live | shadow[i].live;
    end
  end

  always_comb begin
    tail     = shadow[RED_LAT-1];
    red_en   = gnt_vld | flush;
    red_x    = gnt_vld ? gnt_x : '0;
    busy     = gnt_vld | any_live;
    // Dummy results also raise red_valid, so only a missing pulse is detectable.
    mismatch = tail.live & ~red_valid;
    err      = err_q | mismatch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (contend) begin
      ptr <= ~ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RED_LAT; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      shadow[0].live <= gnt_vld;
      shadow[0].src  <= gnt_vld & gnt_src;
      shadow[0].tag  <= gnt_vld ? gnt_tag : '0;
      for (int i = 1; i < RED_LAT; i++) begin
        shadow[i] <= shadow[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp0_y     <= '0;
      rsp0_tag   <= '0;
      rsp1_valid <= 1'b0;
      rsp1_y     <= '0;
      rsp1_tag   <= '0;
    end else begin
      rsp0_valid <= tail.live & ~tail.src;
      rsp1_valid <= tail.live &  tail.src;
      if (tail.live && !tail.src) begin
        rsp0_y   <= red_y;
        rsp0_tag <= tail.tag;
      end
      if (tail.live && tail.src) begin
        rsp1_y   <= red_y;
        rsp1_tag <= tail.tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (mismatch) begin
      err_q <= 1'b1;
    end
  end

endmodule
